blue_diamond_collect: RTL and testbench

Per-frame collision and collection tracker for the level-1 blue diamonds. Once per frame it scans a fixed table of diamond boxes against the water player's bounding box and latches an eaten flag per diamond. Its `is_diamond_eat` bits drive the diamond sprite display stage. Its count and pulse feed the score/HUD and sound logic.

---
 rtl/diamond_pkg.sv | 17 +
 rtl/bbox_overlap.sv | 31 +++
 rtl/blue_diamond_collect.sv | 117 +++++++++++
 tb/tb_blue_diamond_collect.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/diamond_pkg.sv
// Level-1 blue diamond placement table, sprite size and the collection scan FSM encoding.
// Shared by the collection tracker and, later, the red diamond and hazard trackers.
package diamond_pkg;

    localparam int BLUE_DIAM_NUM = 4;
    localparam int DIAM_SIZE     = 20;

    localparam logic [9:0] BLUE_DIAM_X [BLUE_DIAM_NUM] = '{10'd458, 10'd120, 10'd300, 10'd560};
    localparam logic [9:0] BLUE_DIAM_Y [BLUE_DIAM_NUM] = '{10'd408, 10'd300, 10'd180, 10'd60};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } diam_scan_t;

endpackage

// File: rtl/bbox_overlap.sv
// Combinational axis-aligned box overlap test between two top-left-anchored boxes.
// Touching edges are not an overlap; 11-bit sums keep corner+size from wrapping.
module bbox_overlap #(
    parameter int A_W = 20,
    parameter int A_H = 28,
    parameter int B_W = 20,
    parameter int B_H = 20
) (
    input  logic [9:0] i_a_x,
    input  logic [9:0] i_a_y,
    input  logic [9:0] i_b_x,
    input  logic [9:0] i_b_y,
    output logic       o_hit
);

    logic [10:0] w_ax;
    logic [10:0] w_ay;
    logic [10:0] w_bx;
    logic [10:0] w_by;

    assign w_ax = {1'b0, i_a_x};
    assign w_ay = {1'b0, i_a_y};
    assign w_bx = {1'b0, i_b_x};
    assign w_by = {1'b0, i_b_y};

    assign o_hit = (w_ax < w_bx + 11'(B_W)) &&
                   (w_bx < w_ax + 11'(A_W)) &&
                   (w_ay < w_by + 11'(B_H)) &&
                   (w_by < w_ay + 11'(A_H));

endmodule

// File: rtl/blue_diamond_collect.sv
// Once per frame, scans the blue diamond table against the water player's box and latches eaten flags.
// A scan takes NUM_DIAM+1 cycles; frame strobes arriving while a scan is running are dropped.
module blue_diamond_collect
    import diamond_pkg::*;
#(
    parameter int NUM_DIAM = BLUE_DIAM_NUM,
    parameter int PLAYER_W = 20,
    parameter int PLAYER_H = 28
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                frame_clk,
    input  logic                level_restart,
    input  logic [9:0]          water_x,
    input  logic [9:0]          water_y,
    output logic [NUM_DIAM-1:0] is_diamond_eat,
    output logic [3:0]          eat_count,
    output logic                collect_pulse,
    output logic                scan_busy
);

    localparam int IDX_W = (NUM_DIAM > 1) ? $clog2(NUM_DIAM) : 1;

    logic                r_sync0;
    logic                r_sync1;
    logic                r_sync1_d;
    logic                r_frame_edge;

    diam_scan_t          r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [9:0]          r_px;
    logic [9:0]          r_py;
    logic [NUM_DIAM-1:0] r_eaten;
    logic [3:0]          r_count;
    logic                r_pulse;

    logic                w_hit;

    // frame_clk is asynchronous to Clk: two-flop synchronizer, then a registered rising-edge strobe.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sync0      <= 1'b0;
            r_sync1      <= 1'b0;
            r_sync1_d    <= 1'b0;
            r_frame_edge <= 1'b0;
        end else begin
            r_sync0      <= frame_clk;
            r_sync1      <= r_sync0;
            r_sync1_d    <= r_sync1;
            r_frame_edge <= r_sync1 & ~r_sync1_d;
        end
    end

    bbox_overlap #(
        .A_W (PLAYER_W),
        .A_H (PLAYER_H),
        .B_W (DIAM_SIZE),
        .B_H (DIAM_SIZE)
    ) u_overlap (
        .i_a_x (r_px),
        .i_a_y (r_py),
        .i_b_x (BLUE_DIAM_X[r_idx]),
        .i_b_y (BLUE_DIAM_Y[r_idx]),
        .o_hit (w_hit)
    );

    always_ff @(posedge Clk) begin
        if (Reset || level_restart) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_px    <= '0;
            r_py    <= '0;
            r_eaten <= '0;
            r_count <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_frame_edge) begin
                        r_idx   <= '0;
                        r_px    <= water_x;
                        r_py    <= water_y;
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    // Already-eaten diamonds are skipped so revisiting one never re-pulses.
                    if (w_hit && !r_eaten[r_idx]) begin
                        r_eaten[r_idx] <= 1'b1;
                        r_pulse        <= 1'b1;
                        if (r_count < 4'(NUM_DIAM)) begin
                            r_count <= r_count + 4'd1;
                        end
                    end
                    if (r_idx == IDX_W'(NUM_DIAM - 1)) begin
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign is_diamond_eat = r_eaten;
    assign eat_count      = r_count;
    assign collect_pulse  = r_pulse;
    assign scan_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_blue_diamond_collect.sv
// Directed bench for blue_diamond_collect: a queue of expected pulse cycles is filled per frame
// and drained as collect_pulse is observed; flags, count and scan length are checked per frame.
module tb_blue_diamond_collect;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic       level_restart;
    logic [9:0] water_x;
    logic [9:0] water_y;
    logic [3:0] is_diamond_eat;
    logic [3:0] eat_count;
    logic       collect_pulse;
    logic       scan_busy;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         exp_q[$];
    logic [3:0] exp_flags;
    int         exp_cnt;

    always #5 Clk = ~Clk;

    blue_diamond_collect dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .frame_clk      (frame_clk),
        .level_restart  (level_restart),
        .water_x        (water_x),
        .water_y        (water_y),
        .is_diamond_eat (is_diamond_eat),
        .eat_count      (eat_count),
        .collect_pulse  (collect_pulse),
        .scan_busy      (scan_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_flags"}, 32'(is_diamond_eat), 32'(exp_flags));
        check({tag, "_count"}, 32'(eat_count), 32'(exp_cnt));
    endtask

    // Raise frame_clk on a negedge and wait (bounded) for the scan to start.
    // Returns on the first negedge with scan_busy high; that negedge is scan cycle 0.
    task automatic start_frame(input logic [9:0] px, input logic [9:0] py);
        int lat;
        water_x = px;
        water_y = py;
        @(negedge Clk);
        frame_clk = 1'b1;
        lat = 0;
        while (!scan_busy && lat < 20) begin
            @(negedge Clk);
            lat++;
        end
        check("edge_latency", 32'(lat), 32'd4);
    endtask

    task automatic run_frame(input string tag, input logic [9:0] px, input logic [9:0] py,
                             input logic [3:0] new_mask);
        int busy_len;
        start_frame(px, py);
        for (int i = 0; i < 4; i++) begin
            if (new_mask[i]) begin
                exp_q.push_back(i + 1);
                exp_cnt++;
            end
        end
        exp_flags = exp_flags | new_mask;
        // Player input is captured at the frame edge; moving it mid-scan must not matter.
        water_x  = 10'd0;
        water_y  = 10'd0;
        busy_len = 0;
        for (int k = 0; k < 8; k++) begin
            if (scan_busy) busy_len++;
            if (collect_pulse) begin
                if (exp_q.size() == 0) check({tag, "_extra_pulse"}, 32'(k), 32'hFFFF_FFFF);
                else                   check({tag, "_pulse_cycle"}, 32'(k), 32'(exp_q.pop_front()));
            end
            @(negedge Clk);
        end
        check({tag, "_scan_len"}, 32'(busy_len), 32'd5);
        check({tag, "_missing_pulses"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        check_state(tag);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic clear_expect();
        exp_flags = 4'b0000;
        exp_cnt   = 0;
        exp_q.delete();
    endtask

    initial begin
        int scans;
        int busy_seen;
        logic prev_busy;

        Reset         = 1'b1;
        frame_clk     = 1'b0;
        level_restart = 1'b0;
        water_x       = 10'd0;
        water_y       = 10'd0;
        clear_expect();
        repeat (3) @(negedge Clk);
        check("rst_flags", 32'(is_diamond_eat), 32'd0);
        check("rst_count", 32'(eat_count), 32'd0);
        check("rst_pulse", 32'(collect_pulse), 32'd0);
        check("rst_busy", 32'(scan_busy), 32'd0);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);

        // Player far from every diamond.
        for (int f = 0; f < 3; f++) run_frame("origin", 10'd0, 10'd0, 4'b0000);

        // Overlap diamond 0, then stay on it for two more frames.
        run_frame("d0_hit", 10'd450, 10'd400, 4'b0001);
        run_frame("d0_hold1", 10'd450, 10'd400, 4'b0000);
        run_frame("d0_hold2", 10'd450, 10'd400, 4'b0000);

        @(negedge Clk);
        level_restart = 1'b1;
        @(negedge Clk);
        level_restart = 1'b0;
        clear_expect();
        check_state("restart_idle");

        // Right edge exactly touching diamond 0, then one pixel of overlap.
        run_frame("d0_touch", 10'd438, 10'd408, 4'b0000);
        run_frame("d0_edge1", 10'd439, 10'd408, 4'b0001);
        run_frame("d2_hit", 10'd300, 10'd180, 4'b0100);

        // Abort a scan on diamond 3 before it is evaluated.
        start_frame(10'd560, 10'd60);
        @(negedge Clk);
        level_restart = 1'b1;
        @(negedge Clk);
        level_restart = 1'b0;
        clear_expect();
        check_state("abort");
        check("abort_pulse", 32'(collect_pulse), 32'd0);
        check("abort_busy", 32'(scan_busy), 32'd0);
        frame_clk = 1'b0;
        busy_seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            if (scan_busy) busy_seen++;
        end
        check("abort_no_resume", 32'(busy_seen), 32'd0);
        check_state("abort_after");

        // Restart coincides with the frame edge: no scan, diamond 1 stays uneaten.
        water_x = 10'd120;
        water_y = 10'd300;
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        level_restart = 1'b1;
        @(negedge Clk);
        level_restart = 1'b0;
        busy_seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (scan_busy) busy_seen++;
            @(negedge Clk);
        end
        check("restart_edge_no_scan", 32'(busy_seen), 32'd0);
        check_state("restart_edge");
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
        run_frame("d1_hit", 10'd120, 10'd300, 4'b0010);

        // Two frame_clk rising edges two cycles apart: the second lands mid-scan and is dropped.
        water_x = 10'd560;
        water_y = 10'd60;
        @(negedge Clk);
        frame_clk = 1'b1;
        @(negedge Clk);
        frame_clk = 1'b0;
        @(negedge Clk);
        frame_clk = 1'b1;
        exp_q.push_back(4);
        exp_flags = exp_flags | 4'b1000;
        exp_cnt++;
        scans     = 0;
        prev_busy = 1'b0;
        busy_seen = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge Clk);
            if (scan_busy && !prev_busy) begin
                scans++;
                busy_seen = 0;
            end
            if (collect_pulse) begin
                if (exp_q.size() == 0) check("dbl_extra_pulse", 32'(busy_seen), 32'hFFFF_FFFF);
                else                   check("dbl_pulse_cycle", 32'(busy_seen), 32'(exp_q.pop_front()));
            end
            if (busy_seen >= 0) busy_seen++;
            prev_busy = scan_busy;
        end
        check("dbl_scan_count", 32'(scans), 32'd1);
        check("dbl_missing_pulses", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        check_state("dbl");
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);

        // Reset clears everything collected so far.
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        clear_expect();
        check_state("final_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
